maxpool: RTL and testbench
==========================

MAXPOOL -- requirements
Module: maxpool

Interface
REQ-001 Parameter DATA_SIZE, default 16: width of data words and of the shape inputs.
REQ-002 Parameter MEM_SIZE, default 16: width of memory addresses.
REQ-003 Parameter LOOP_BIT, default 8: width of each internal loop counter.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 en  input  1: start request, sampled only in IDLE.
REQ-007 R, C  input  DATA_SIZE each: output feature-map rows and columns.
REQ-008 M  input  DATA_SIZE: channel count.
REQ-009 K  input  DATA_SIZE: square window size.
REQ-010 S  input  DATA_SIZE: window stride.
REQ-011 IR, IC  input  DATA_SIZE each: input feature-map rows and columns (conv output map).
REQ-012 in_rd  input  DATA_SIZE: read data from the conv output memory, signed two's complement.
REQ-013 in_ra  output  MEM_SIZE: read address into the conv output memory.
REQ-014 out_we  output  1: pooled-result write enable.
REQ-015 out_wa  output  MEM_SIZE: pooled-result write address.
REQ-016 out_wd  output  DATA_SIZE: pooled-result write data.
REQ-017 done  output  1: one-cycle completion pulse.

Function
REQ-018 Memory contract: in_rd returns the word at the in_ra presented in the previous cycle (1-cycle read latency).
REQ-019 States: IDLE, RUN, DRAIN, FIN. Transitions: IDLE->RUN on en=1 with all of R, C, M and K nonzero; IDLE->FIN on en=1 with any of them zero; RUN->DRAIN after the last read issue; DRAIN->FIN after 2 cycles; FIN->IDLE unconditionally.
REQ-020 R, C, M, K, S, IR and IC are latched on the IDLE->RUN/FIN edge; later changes have no effect until the next start.
REQ-021 en while not in IDLE is ignored.
REQ-022 Loop nest, outermost to innermost: mm<M, rr<R, cc<C, ii<K, jj<K.
REQ-023 RUN issues exactly one read per cycle, with no bubbles between windows: T = M*R*C*K*K issue cycles in total.
REQ-024 in_ra = mm*IR*IC + (rr*S+ii)*IC + (cc*S+jj), computed modulo 2^MEM_SIZE.
REQ-025 Window bounds are not checked; keeping every window inside IR x IC is the caller's responsibility.
REQ-026 The first element of each window loads the max register directly; each later element replaces it only if it is strictly greater as a signed value.
REQ-027 A window whose last read issues in cycle n produces out_we=1 for exactly cycle n+2, with out_wd = window max and out_wa = mm*R*C + rr*C + cc (modulo 2^MEM_SIZE).
REQ-028 out_we, out_wa and out_wd are driven from registers.
REQ-029 Counting from the first RUN cycle as cycle 0, done=1 in cycle T+2 only, one cycle after the final out_we.
REQ-030 Zero-size start (REQ-019 IDLE->FIN): no reads and no writes; done=1 in the cycle after en was sampled.
REQ-031 in_ra = 0 and out_we = 0 whenever the state is IDLE or FIN.
REQ-032 When RUN ends, windows still in flight complete in DRAIN, so no pooled result is lost.

Reset
REQ-033 While rst=1: state=IDLE; all counters 0; in_ra=0, out_we=0, out_wa=0, out_wd=0, done=0; latched parameters and max register cleared.
REQ-034 rst asserted mid-operation aborts immediately, discards pending writes and issues no done.
REQ-035 After rst deasserts, the block waits in IDLE for a fresh en.

Verification
REQ-036 IR=IC=4, M=1, K=2, S=2, R=C=2, memory[i]=i for i=0..15 -> writes (wa,wd)=(0,5),(1,7),(2,13),(3,15); 16 read cycles; done in cycle 18.
REQ-037 Single 2x2 window containing -3,-1,-7,-2 (16-bit) -> one write with wd=0xFFFF (-1); an all-zero-initialised max register would give 0, which is wrong.
REQ-038 IR=IC=3, K=3, S=1, R=C=1, maximum 42 located at address 8 -> one write (0,42) after 9 read cycles; done in cycle 11.
REQ-039 Same setup as REQ-036 but M=2, channel 1 = channel 0 + 100 -> channel 1 read addresses start at 16; writes (4,105),(5,107),(6,113),(7,115).
REQ-040 R=0 with en=1 -> no reads, out_we never asserted, done pulses in the next cycle; en pulsed during a run -> ignored.
REQ-041 rst pulsed while the write of cycle n+2 is pending -> no write and no done occur; a new en restarts the run from in_ra=0.

Source files
------------

// File: rtl/maxpool.sv
// Max-pooling engine: streams a conv output map through a 1-cycle-latency read
// port, one read per cycle, and writes one signed maximum per KxK window.
module maxpool #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned MEM_SIZE  = 16,
  parameter int unsigned LOOP_BIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] R,
  input  logic [DATA_SIZE-1:0] C,
  input  logic [DATA_SIZE-1:0] M,
  input  logic [DATA_SIZE-1:0] K,
  input  logic [DATA_SIZE-1:0] S,
  input  logic [DATA_SIZE-1:0] IR,
  input  logic [DATA_SIZE-1:0] IC,
  input  logic [DATA_SIZE-1:0] in_rd,
  output logic [MEM_SIZE-1:0]  in_ra,
  output logic                 out_we,
  output logic [MEM_SIZE-1:0]  out_wa,
  output logic [DATA_SIZE-1:0] out_wd,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

  state_e               state_q;
  logic                 drain_q;
  logic [DATA_SIZE-1:0] r_q, c_q, m_q, k_q, s_q, ir_q, ic_q;
  logic [LOOP_BIT-1:0]  mm_q, rr_q, cc_q, ii_q, jj_q;
  logic [LOOP_BIT-1:0]  mm_d, rr_d, cc_d, ii_d, jj_d;
  logic [MEM_SIZE-1:0]  in_ra_q, ra_d, wa_d;
  logic                 out_we_q, done_q;
  logic [MEM_SIZE-1:0]  out_wa_q;
  logic [DATA_SIZE-1:0] out_wd_q, max_q, new_max;
  // Tag travelling alongside the read that returns data in the current cycle
  logic                 v1_q, first1_q, last1_q;
  logic [MEM_SIZE-1:0]  wa1_q;
  logic jj_last, ii_last, cc_last, rr_last, mm_last, win_last, run_last, size_ok;

  assign jj_last  = (DATA_SIZE'(jj_q) == k_q - DATA_SIZE'(1));
  assign ii_last  = (DATA_SIZE'(ii_q) == k_q - DATA_SIZE'(1));
  assign cc_last  = (DATA_SIZE'(cc_q) == c_q - DATA_SIZE'(1));
  assign rr_last  = (DATA_SIZE'(rr_q) == r_q - DATA_SIZE'(1));
  assign mm_last  = (DATA_SIZE'(mm_q) == m_q - DATA_SIZE'(1));
  assign win_last = ii_last && jj_last;
  assign run_last = win_last && cc_last && rr_last && mm_last;
  assign size_ok  = (|R) && (|C) && (|M) && (|K);

  // Loop nest mm > rr > cc > ii > jj
  always_comb begin
    mm_d = mm_q;
    rr_d = rr_q;
    cc_d = cc_q;
    ii_d = ii_q;
    jj_d = jj_q;
    if (!jj_last) begin
      jj_d = jj_q + LOOP_BIT'(1);
    end else begin
      jj_d = '0;
      if (!ii_last) begin
        ii_d = ii_q + LOOP_BIT'(1);
      end else begin
        ii_d = '0;
        if (!cc_last) begin
          cc_d = cc_q + LOOP_BIT'(1);
        end else begin
          cc_d = '0;
          if (!rr_last) begin
            rr_d = rr_q + LOOP_BIT'(1);
          end else begin
            rr_d = '0;
            mm_d = mm_q + LOOP_BIT'(1);
          end
        end
      end
    end
  end

  assign ra_d = MEM_SIZE'(mm_d) * MEM_SIZE'(ir_q) * MEM_SIZE'(ic_q)
              + (MEM_SIZE'(rr_d) * MEM_SIZE'(s_q) + MEM_SIZE'(ii_d)) * MEM_SIZE'(ic_q)
              + MEM_SIZE'(cc_d) * MEM_SIZE'(s_q) + MEM_SIZE'(jj_d);
  assign wa_d = MEM_SIZE'(mm_q) * MEM_SIZE'(r_q) * MEM_SIZE'(c_q)
              + MEM_SIZE'(rr_q) * MEM_SIZE'(c_q) + MEM_SIZE'(cc_q);
  assign new_max = (first1_q || ($signed(in_rd) > $signed(max_q))) ? in_rd : max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      drain_q  <= 1'b0;
      {r_q, c_q, m_q, k_q, s_q, ir_q, ic_q} <= '0;
      {mm_q, rr_q, cc_q, ii_q, jj_q} <= '0;
      in_ra_q  <= '0;
      out_we_q <= 1'b0;
      out_wa_q <= '0;
      out_wd_q <= '0;
      done_q   <= 1'b0;
      max_q    <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      wa1_q    <= '0;
    end else begin
      out_we_q <= 1'b0;
      done_q   <= 1'b0;
      v1_q     <= 1'b0;
      if (v1_q) begin
        max_q <= new_max;
        if (last1_q) begin
          out_we_q <= 1'b1;
          out_wa_q <= wa1_q;
          out_wd_q <= new_max;
        end
      end
      case (state_q)
        IDLE: begin
          if (en) begin
            {r_q, c_q, m_q, k_q, s_q, ir_q, ic_q} <= {R, C, M, K, S, IR, IC};
            {mm_q, rr_q, cc_q, ii_q, jj_q} <= '0;
            in_ra_q <= '0;
            if (size_ok) begin
              state_q <= RUN;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          v1_q     <= 1'b1;
          first1_q <= (ii_q == '0) && (jj_q == '0);
          last1_q  <= win_last;
          wa1_q    <= wa_d;
          {mm_q, rr_q, cc_q, ii_q, jj_q} <= {mm_d, rr_d, cc_d, ii_d, jj_d};
          if (run_last) begin
            state_q <= DRAIN;
            drain_q <= 1'b0;
            in_ra_q <= '0;
          end else begin
            in_ra_q <= ra_d;
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ra  = in_ra_q;
  assign out_we = out_we_q;
  assign out_wa = out_wa_q;
  assign out_wd = out_wd_q;
  assign done   = done_q;

endmodule

// File: tb/tb_maxpool.sv
// Directed bench for maxpool: behavioural 1-cycle-latency memory, per-cycle
// capture of reads, writes and done, compared against hand-computed values.
module tb_maxpool;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] R, C, M, K, S, IR, IC;
  logic [15:0] in_rd;
  logic [15:0] in_ra;
  logic        out_we;
  logic [15:0] out_wa;
  logic [15:0] out_wd;
  logic        done;

  logic [15:0] mem [256];
  logic [15:0] ra_log [64];
  logic [15:0] wr_wa [16];
  logic [15:0] wr_wd [16];
  int          wr_cyc [16];
  int          wr_n, done_cnt, done_cyc;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] ra_or;

  maxpool dut (
    .clk(clk), .rst(rst), .en(en),
    .R(R), .C(C), .M(M), .K(K), .S(S), .IR(IR), .IC(IC),
    .in_rd(in_rd), .in_ra(in_ra),
    .out_we(out_we), .out_wa(out_wa), .out_wd(out_wd), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) in_rd <= mem[in_ra[7:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setp(input int r, input int c, input int m, input int k,
                      input int s, input int ir, input int ic);
    R = 16'(r); C = 16'(c); M = 16'(m); K = 16'(k);
    S = 16'(s); IR = 16'(ir); IC = 16'(ic);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 16; i++) begin
      mem[i]      = 16'(i);
      mem[16 + i] = 16'(i + 100);
    end
  endtask

  // Cycle 0 is the cycle after the edge that samples en
  task automatic run_op(input int ncyc, input int pulse_cyc, input int rst_cyc);
    wr_n = 0; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      ra_log[cyc] = in_ra;
      if (out_we) begin
        if (wr_n < 16) begin
          wr_wa[wr_n] = out_wa; wr_wd[wr_n] = out_wd; wr_cyc[wr_n] = cyc;
        end
        wr_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == pulse_cyc) begin
        en = 1'b1;
        R  = 16'h0;
      end else begin
        en = 1'b0;
      end
      if (cyc == rst_cyc) rst = 1'b1;
      else if (cyc == rst_cyc + 1) rst = 1'b0;
    end
    en = 1'b0;
  endtask

  task automatic check_ramp(input string tag);
    chk({tag, "_nwr"}, 32'(wr_n), 4);
    chk({tag, "_wa0"}, 32'(wr_wa[0]), 0);
    chk({tag, "_wd0"}, 32'(wr_wd[0]), 5);
    chk({tag, "_wd1"}, 32'(wr_wd[1]), 7);
    chk({tag, "_wd2"}, 32'(wr_wd[2]), 13);
    chk({tag, "_wa3"}, 32'(wr_wa[3]), 3);
    chk({tag, "_wd3"}, 32'(wr_wd[3]), 15);
    chk({tag, "_ra0"}, 32'(ra_log[0]), 0);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 18);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    setp(0, 0, 0, 0, 0, 0, 0);
    load_ramp();
    repeat (3) @(negedge clk);
    chk("rst_in_ra", 32'(in_ra), 0);
    chk("rst_out_we", 32'(out_we), 0);
    chk("rst_out_wa", 32'(out_wa), 0);
    chk("rst_out_wd", 32'(out_wd), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // 4x4 ramp, 2x2 windows stride 2
    setp(2, 2, 1, 2, 2, 4, 4);
    run_op(24, -1, -1);
    check_ramp("ramp");
    chk("ramp_ra1", 32'(ra_log[1]), 1);
    chk("ramp_ra2", 32'(ra_log[2]), 4);
    chk("ramp_ra15", 32'(ra_log[15]), 15);
    chk("ramp_ra16", 32'(ra_log[16]), 0);
    chk("ramp_wr0_cyc", 32'(wr_cyc[0]), 5);
    chk("ramp_wr3_cyc", 32'(wr_cyc[3]), 17);
    chk("ramp_done_cnt", 32'(done_cnt), 1);

    // Reset while the first window's write is pending
    run_op(30, -1, 4);
    chk("abort_nwr", 32'(wr_n), 0);
    chk("abort_done_cnt", 32'(done_cnt), 0);
    chk("abort_ra_idle", 32'(ra_log[20]), 0);
    run_op(24, -1, -1);
    check_ramp("restart");

    // Two channels, en pulse with R=0 mid-run must be ignored
    setp(2, 2, 2, 2, 2, 4, 4);
    run_op(40, 10, -1);
    chk("ch2_nwr", 32'(wr_n), 8);
    chk("ch2_wd0", 32'(wr_wd[0]), 5);
    chk("ch2_wa4", 32'(wr_wa[4]), 4);
    chk("ch2_wd4", 32'(wr_wd[4]), 105);
    chk("ch2_wa5", 32'(wr_wa[5]), 5);
    chk("ch2_wd5", 32'(wr_wd[5]), 107);
    chk("ch2_wd6", 32'(wr_wd[6]), 113);
    chk("ch2_wa7", 32'(wr_wa[7]), 7);
    chk("ch2_wd7", 32'(wr_wd[7]), 115);
    chk("ch2_ra16", 32'(ra_log[16]), 16);
    chk("ch2_ra31", 32'(ra_log[31]), 31);
    chk("ch2_done_cyc", 32'(done_cyc), 34);
    chk("ch2_done_cnt", 32'(done_cnt), 1);

    // All-negative window: max must be -1, not 0
    mem[0] = 16'hFFFD; mem[1] = 16'hFFFF; mem[2] = 16'hFFF9; mem[3] = 16'hFFFE;
    setp(1, 1, 1, 2, 2, 2, 2);
    run_op(12, -1, -1);
    chk("neg_nwr", 32'(wr_n), 1);
    chk("neg_wa", 32'(wr_wa[0]), 0);
    chk("neg_wd", 32'(wr_wd[0]), 32'h0000FFFF);
    chk("neg_wr_cyc", 32'(wr_cyc[0]), 5);
    chk("neg_done_cyc", 32'(done_cyc), 6);

    // Single 3x3 window with its maximum at the last address
    for (int i = 0; i < 9; i++) mem[i] = 16'(3 * i);
    mem[8] = 16'd42;
    setp(1, 1, 1, 3, 1, 3, 3);
    run_op(16, -1, -1);
    chk("k3_nwr", 32'(wr_n), 1);
    chk("k3_wa", 32'(wr_wa[0]), 0);
    chk("k3_wd", 32'(wr_wd[0]), 42);
    chk("k3_wr_cyc", 32'(wr_cyc[0]), 10);
    chk("k3_ra4", 32'(ra_log[4]), 4);
    chk("k3_ra8", 32'(ra_log[8]), 8);
    chk("k3_done_cyc", 32'(done_cyc), 11);

    // Zero-size start
    setp(0, 2, 1, 2, 2, 4, 4);
    run_op(6, -1, -1);
    ra_or = '0;
    for (int i = 0; i < 6; i++) ra_or = ra_or | ra_log[i];
    chk("zero_nwr", 32'(wr_n), 0);
    chk("zero_ra", 32'(ra_or), 0);
    chk("zero_done_cyc", 32'(done_cyc), 0);
    chk("zero_done_cnt", 32'(done_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
